// File: rtl/axi_rd_burst_slave.sv
// axi_rd_burst_slave
//   AXI4 read-channel slave backed by an internal word memory. Accepted AR
//   requests are queued and returned in order on R as FIXED / INCR / WRAP
//   bursts with full valid/ready backpressure. Memory contents are loaded
//   through a backdoor write port.
//
// Optional feature macro: AXI_RD_PROTOCOL_CHECK_EN
//   When defined, illegal requests (oversized beat, bad WRAP length, unaligned
//   WRAP start, INCR crossing 4 KB) return SLVERR on every beat and pulse the
//   internal protocol_err flag. When undefined they are served normally.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   ar_valid/ar_ready   AR handshake; ar_addr, ar_id, ar_len, ar_size, ar_burst
//   r_valid/r_ready     R handshake; r_data, r_resp, r_last, r_id
//   bd_we/bd_addr/bd_data  backdoor memory write (word indexed)

module axi_rd_burst_slave #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 1,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ar_valid,
    output logic                     ar_ready,
    input  logic [31:0]              ar_addr,
    input  logic [ID_W-1:0]          ar_id,
    input  logic [7:0]               ar_len,
    input  logic [2:0]               ar_size,
    input  logic [1:0]               ar_burst,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [DATA_W-1:0]        r_data,
    output logic [1:0]               r_resp,
    output logic                     r_last,
    output logic [ID_W-1:0]          r_id,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [DATA_W-1:0]        bd_data
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LANE = $clog2(DATA_W / 8);
    localparam int unsigned QW   = $clog2(MAX_OUT);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, BEAT} state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Memory
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
    end

    // ------------------------------------------------------------------
    // AR queue
    // ------------------------------------------------------------------
    logic [31:0]     q_addr  [MAX_OUT];
    logic [ID_W-1:0] q_id    [MAX_OUT];
    logic [7:0]      q_len   [MAX_OUT];
    logic [2:0]      q_size  [MAX_OUT];
    logic [1:0]      q_burst [MAX_OUT];

    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   q_cnt;    // entries waiting in storage
    logic [QW:0]   out_cnt;  // accepted but not yet finished (includes the active burst)
    logic [QW:0]   out_next;

    logic push, pop, advance, last_hs;

    assign push = ar_valid && ar_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[wr_ptr]  <= ar_addr;
            q_id[wr_ptr]    <= ar_id;
            q_len[wr_ptr]   <= ar_len;
            q_size[wr_ptr]  <= ar_size;
            q_burst[wr_ptr] <= ar_burst;
        end
    end

    // Head-of-queue fields and the per-burst constants derived from them.
    logic [31:0]     h_addr, h_bytes, h_cont, h_off;
    logic [ID_W-1:0] h_id;
    logic [7:0]      h_len;
    logic [2:0]      h_size;
    logic [1:0]      h_burst;

    assign h_addr  = q_addr[rd_ptr];
    assign h_id    = q_id[rd_ptr];
    assign h_len   = q_len[rd_ptr];
    assign h_size  = q_size[rd_ptr];
    assign h_burst = q_burst[rd_ptr];
    assign h_bytes = 32'd1 << h_size;
    assign h_cont  = h_bytes * (32'(h_len) + 32'd1);
    assign h_off   = h_addr % h_cont;

    logic protocol_err;

`ifdef AXI_RD_PROTOCOL_CHECK_EN
    logic h_bad;

    always_comb begin
        h_bad = 1'b0;
        if (32'(h_size) > LANE)
            h_bad = 1'b1;
        if (h_burst == BURST_WRAP) begin
            if (!(h_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                h_bad = 1'b1;
            if ((h_addr & (h_bytes - 32'd1)) != 32'd0)
                h_bad = 1'b1;
        end
        if ((h_burst == BURST_INCR) &&
            (((32'(h_addr[11:0]) & ~(h_bytes - 32'd1)) + h_cont) > 32'd4096))
            h_bad = 1'b1;
    end

    assign protocol_err = pop && h_bad;
`else
    assign protocol_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Active burst registers
    // ------------------------------------------------------------------
    logic [31:0]     cur_addr, cur_bytes, cur_cont, cur_off, cur_base;
    logic [ID_W-1:0] cur_id;
    logic [7:0]      cur_len, beat_cnt;
    logic [1:0]      cur_burst;
    logic            cur_err;

    // WRAP keeps an offset inside the container; since the offset is below the
    // container and B never exceeds it, one conditional subtract is the modulo.
    logic [31:0] off_sum, next_off, next_addr;

    always_comb begin
        off_sum  = cur_off + cur_bytes;
        next_off = (off_sum >= cur_cont) ? (off_sum - cur_cont) : off_sum;
        case (cur_burst)
            BURST_INCR: next_addr = cur_addr + cur_bytes;
            BURST_WRAP: next_addr = cur_base + next_off;
            BURST_FIXED: next_addr = cur_addr;
            default:    next_addr = cur_addr;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        last_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (q_cnt != '0) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = BEAT;
            BEAT: begin
                if (r_ready) begin
                    if (beat_cnt != cur_len) begin
                        advance    = 1'b1;
                        state_next = LOAD;
                    end else begin
                        last_hs = 1'b1;
                        if (q_cnt != '0) begin
                            pop        = 1'b1;
                            state_next = LOAD;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign r_valid = (state == BEAT);
    assign r_id    = cur_id;

    // ------------------------------------------------------------------
    // Queue bookkeeping and registered ar_ready
    // ------------------------------------------------------------------
    assign out_next = out_cnt + {{QW{1'b0}}, push} - {{QW{1'b0}}, last_hs};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            out_cnt  <= '0;
            ar_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            q_cnt    <= q_cnt + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};
            out_cnt  <= out_next;
            ar_ready <= (out_next != (QW+1)'(MAX_OUT));
        end
    end

    // ------------------------------------------------------------------
    // Burst datapath and R outputs
    // ------------------------------------------------------------------
    logic [31:0] word_idx;
    logic        beat_err;

    assign word_idx = cur_addr >> LANE;
    assign beat_err = (word_idx >= DEPTH) || (cur_burst == 2'b11) || cur_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_addr  <= '0;
            cur_bytes <= '0;
            cur_cont  <= '0;
            cur_off   <= '0;
            cur_base  <= '0;
            cur_id    <= '0;
            cur_len   <= '0;
            cur_burst <= '0;
            cur_err   <= 1'b0;
            beat_cnt  <= '0;
            r_data    <= '0;
            r_resp    <= '0;
            r_last    <= 1'b0;
        end else begin
            if (pop) begin
                cur_addr  <= h_addr;
                cur_bytes <= h_bytes;
                cur_cont  <= h_cont;
                cur_off   <= h_off;
                cur_base  <= h_addr - h_off;
                cur_id    <= h_id;
                cur_len   <= h_len;
                cur_burst <= h_burst;
                cur_err   <= protocol_err;
                beat_cnt  <= '0;
            end else if (advance) begin
                cur_addr <= next_addr;
                cur_off  <= next_off;
                beat_cnt <= beat_cnt + 8'd1;
            end
            // Synchronous read; a same-edge backdoor write is not yet visible.
            if (state == LOAD) begin
                r_data <= beat_err ? '0 : mem[word_idx[AW-1:0]];
                r_resp <= beat_err ? 2'b10 : 2'b00;
                r_last <= (beat_cnt == cur_len);
            end
        end
    end

endmodule

// File: doc/axi_rd_burst_slave.md
Name: axi_rd_burst_slave

Overview:
- Parametrised AXI4 read-channel slave with an internal word memory.
- Generalises the fixed 64-bit, 1-bit-ID read channel of our AXI interface: data width, ID width, memory depth and outstanding-burst depth are all parameters.
- Accepts and queues multiple AR bursts, then returns FIXED/INCR/WRAP bursts in order on R with full valid/ready backpressure.
- Sits behind the AXI VIP as the DUT-side read responder; contents are loaded through a backdoor write port.

Parameters:
DATA_W, 64, R data width in bits (power of 2, 32..1024)
ID_W, 1, width of ar_id / r_id
DEPTH, 1024, memory depth in DATA_W words (power of 2)
MAX_OUT, 4, AR queue depth = maximum accepted-but-unfinished bursts (power of 2, >=2)

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
ar_addr  in  32  byte address
ar_id  in  ID_W  transaction ID
ar_len  in  8  beats minus 1
ar_size  in  3  log2 bytes per beat
ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
r_valid  out  1  read data valid
r_ready  in  1  read data ready
r_data  out  DATA_W  read data
r_resp  out  2  00 OKAY, 10 SLVERR
r_last  out  1  final beat of burst
r_id  out  ID_W  ID of burst being returned
bd_we  in  1  backdoor write enable
bd_addr  in  log2(DEPTH)  backdoor word index
bd_data  in  DATA_W  backdoor write data

Behaviour:
- Reset (reset=0, asynchronous): ar_ready=0, r_valid=0, r_last=0, r_resp=0, r_data=0, r_id=0; AR queue emptied; FSM to IDLE. Memory contents are not reset.
- After reset release: ar_ready = !queue_full, registered.
- AR handshake: ar_valid&&ar_ready pushes {addr,id,len,size,burst} into the queue. ar_ready deasserts the cycle after the queue becomes full.
- FSM states:
  - IDLE: queue not empty -> pop the head into the burst registers, go to LOAD.
  - LOAD: read the memory synchronously -> BEAT.
  - BEAT: r_valid=1, outputs held stable until r_ready.
  - On handshake, not last: next address, go to LOAD.
  - On handshake, last: go to IDLE, or pop the next burst straight into LOAD.
  - Latency: AR handshake to first r_valid = 3 cycles when the queue was empty; 2 cycles per beat (1 bubble) under constant r_ready.
- Address generation, with B = 1<<ar_size:
  - FIXED: address unchanged every beat.
  - INCR: address += B, 32-bit wrap-around.
  - WRAP: container = B*(len+1); address = base + ((address+B) mod container), where base = start aligned down to the container size.
- Data and response:
  - Word index = address >> log2(DATA_W/8).
  - Index >= DEPTH -> r_resp=10 (SLVERR), r_data=0; otherwise r_resp=00 and the memory word.
  - r_data is the full word; narrow-beat lane selection is the master's responsibility.
- Reserved burst type (11): all beats SLVERR, len honoured.
- r_last=1 only on beat len; a len=0 burst is a single beat with r_last=1.
- Bursts complete in acceptance order; no interleaving across IDs.
- Simultaneous push and pop of the queue when full is allowed; count is unchanged.
- Backdoor port: bd_we writes the memory on the clock edge. When it coincides with a LOAD read of the same word, the read returns the old data.

Optional Feature:
- Macro AXI_RD_PROTOCOL_CHECK_EN.
- Defined: the whole burst returns SLVERR (data 0) when any of these hold:
  - ar_size > log2(DATA_W/8);
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address;
  - INCR crossing a 4 KB boundary.
  Each violation also pulses an internal protocol_err flag visible to the bench.
- Undefined: these cases are served with the normal address arithmetic and OKAY response.

Test Plan:
- Reset mid-burst: assert reset during beat 2 of len=7 -> r_valid=0 and ar_ready=0 the same cycle; ar_ready=1 one cycle after release; no stale beats.
- INCR, DATA_W=64: preload words 0..7 = 0x100+i; AR addr 0x0, len 3, size 3 -> 4 beats data 0x100..0x103, r_last on beat 4, r_resp 00, r_id echoes ar_id.
- WRAP: AR addr 0x18, len 3, size 3 -> word sequence 3,0,1,2.
- Queue full and backpressure: hold r_ready=0 and issue 5 ARs with MAX_OUT=4 -> exactly 4 accepted and ar_ready=0 until the first burst finishes; order of r_id matches AR order.
- Out of range: AR to word DEPTH-1, INCR len 1 -> beat 1 OKAY, beat 2 SLVERR with data 0.
- With AXI_RD_PROTOCOL_CHECK_EN: WRAP len 2 -> 3 beats, all SLVERR. Without the macro: the same burst returns OKAY.
